// File: rtl/decode_stage.sv
// Registered N-lane RV32I decode stage with valid/ready flow control, wrapping sequence ids and flush.
// Optional illegal-instruction flag per lane is enabled by defining DECODE_ILLEGAL_DETECT_EN.
module decode_stage #(
  parameter int N_LANES = 2,
  parameter int SEQ_W   = 6,
`ifdef DECODE_ILLEGAL_DETECT_EN
  localparam int DEC_W  = 68
`else
  localparam int DEC_W  = 67
`endif
) (
  input  logic                     clk,
  input  logic                     rst_aL,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_LANES-1:0]       in_mask,
  input  logic [32*N_LANES-1:0]    in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_LANES-1:0]       out_mask,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [DEC_W*N_LANES-1:0] out_dec
);

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Handshake: a group moves in when in_valid & in_ready, and out when out_valid & out_ready.
  // The held group is frozen while out_valid & ~out_ready; flush blocks input and drops the held group.

  logic [SEQ_W-1:0]         seq_next;
  logic [N_LANES-1:0]       prefix;
  logic [SEQ_W-1:0]         count;
  logic [DEC_W*N_LANES-1:0] dec_group;
  logic                     push;

  function automatic logic [DEC_W-1:0] decode_lane(input logic [31:0] ins);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        is_op, is_opi, is_ld, is_st, is_br, is_lu, is_au, is_jl, is_jr;
    logic        t_r, t_i, t_s, t_b, t_u, t_j;
    logic [31:0] imm;
    logic [66:0] pkt;
`ifdef DECODE_ILLEGAL_DETECT_EN
    logic        illegal;
`endif
    op     = ins[6:0];
    f3     = ins[14:12];
    is_op  = (op == OP_OP);
    is_opi = (op == OP_OP_IMM);
    is_ld  = (op == OP_LOAD);
    is_st  = (op == OP_STORE);
    is_br  = (op == OP_BRANCH);
    is_lu  = (op == OP_LUI);
    is_au  = (op == OP_AUIPC);
    is_jl  = (op == OP_JAL);
    is_jr  = (op == OP_JALR);
    t_r = is_op;
    t_i = is_opi | is_ld | is_jr;
    t_s = is_st;
    t_b = is_br;
    t_u = is_lu | is_au;
    t_j = is_jl;
`ifdef DECODE_ILLEGAL_DETECT_EN
    illegal = (ins[1:0] != 2'b11) |
              ~(is_op | is_opi | is_ld | is_st | is_br | is_lu | is_au | is_jl | is_jr);
    if (illegal) begin
      {t_r, t_i, t_s, t_b, t_u, t_j} = 6'b0;
    end
`endif
    imm = 32'h0;
    if (t_i)      imm = {{20{ins[31]}}, ins[31:20]};
    else if (t_s) imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    else if (t_b) imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    else if (t_u) imm = {ins[31:12], 12'h000};
    else if (t_j) imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    pkt = {t_r | t_i | t_u | t_j,              // rd_valid
           t_r | t_s | t_b,                    // rs2_valid
           t_r | t_i | t_s | t_b,              // rs1_valid
           ins[11:7], ins[24:20], ins[19:15], f3, imm,
           t_r, t_i, t_s, t_b, t_u, t_j,
           is_op & (f3 == 3'b000) & ins[30],
           (is_op | is_opi) & (f3 == 3'b101) & ins[30],
           is_lu, is_jr, is_ld | is_st,
           f3[1:0], f3[2]};
`ifdef DECODE_ILLEGAL_DETECT_EN
    return {illegal, pkt};
`else
    return pkt;
`endif
  endfunction

  // Only the contiguous run of set mask bits starting at lane 0 is kept.
  always_comb begin
    logic run;
    run       = 1'b1;
    prefix    = '0;
    count     = '0;
    dec_group = '0;
    for (int i = 0; i < N_LANES; i++) begin
      run       = run & in_mask[i];
      prefix[i] = run;
      count     = count + SEQ_W'(run);
      if (run) dec_group[i*DEC_W +: DEC_W] = decode_lane(in_instr[i*32 +: 32]);
    end
  end

  assign in_ready = ~flush & (~out_valid | out_ready);
  assign push     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      out_valid <= 1'b0;
      out_mask  <= '0;
      out_seq   <= '0;
      out_dec   <= '0;
      seq_next  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (push) begin
      out_valid <= |prefix;
      out_mask  <= prefix;
      out_seq   <= seq_next;
      out_dec   <= dec_group;
      seq_next  <= seq_next + count;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table for decode/sequencing plus hand sequences
// for back-pressure, flush, pop and asynchronous reset.
module tb_decode_stage;

  localparam int N_LANES = 2;
  localparam int SEQ_W   = 3;
`ifdef DECODE_ILLEGAL_DETECT_EN
  localparam int DEC_W   = 68;
`else
  localparam int DEC_W   = 67;
`endif

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h407302B3;
  localparam logic [31:0] I_LW    = 32'hFFC12203;
  localparam logic [31:0] I_SRAI  = 32'h4030D093;
  localparam logic [31:0] I_SW    = 32'h00512423;
  localparam logic [31:0] I_BEQ   = 32'hFE208CE3;
  localparam logic [31:0] I_LUI   = 32'h123453B7;
  localparam logic [31:0] I_JAL   = 32'h010000EF;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_AUIPC = 32'h00001517;
  localparam logic [31:0] I_ZERO  = 32'h00000000;

  localparam logic [5:0] T_R = 6'b100000, T_I = 6'b010000, T_S = 6'b001000;
  localparam logic [5:0] T_B = 6'b000100, T_U = 6'b000010, T_J = 6'b000001;

  logic                     clk = 1'b0;
  logic                     rst_aL = 1'b0;
  logic                     flush = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [N_LANES-1:0]       in_mask = '0;
  logic [32*N_LANES-1:0]    in_instr = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [N_LANES-1:0]       out_mask;
  logic [SEQ_W-1:0]         out_seq;
  logic [DEC_W*N_LANES-1:0] out_dec;

  int total = 0;
  int bad   = 0;

  decode_stage #(.N_LANES(N_LANES), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_seq(out_seq), .out_dec(out_dec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       mask;
    logic [31:0]      i0;
    logic [31:0]      i1;
    logic             ev;
    logic [1:0]       em;
    logic [2:0]       es;
    logic [DEC_W-1:0] d0;
    logic [DEC_W-1:0] d1;
  } vec_t;

  vec_t vecs[8];
  logic [DEC_W-1:0] p_add, p_sub, p_lw, p_srai, p_sw, p_beq, p_lui, p_jal, p_jalr, p_auipc, p_zero;

  function automatic logic [DEC_W-1:0] mk(
    input logic rdv, input logic rs2v, input logic rs1v,
    input logic [4:0] rd, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3,
    input logic [31:0] imm, input logic [5:0] typ,
    input logic sub, input logic sra, input logic lui, input logic jalr, input logic ls,
    input logic [1:0] w, input logic sg);
    logic [66:0] p;
    p = {rdv, rs2v, rs1v, rd, rs2, rs1, f3, imm, typ, sub, sra, lui, jalr, ls, w, sg};
    return DEC_W'(p);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] i0,
                       input logic [31:0] i1, input logic ordy, input logic fl);
    in_valid  = v;
    in_mask   = m;
    in_instr  = {i1, i0};
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_group(input string nm, input logic [2:0] seq,
                           input logic [DEC_W-1:0] d0, input logic [DEC_W-1:0] d1);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_seq"}, out_seq, seq);
    chk({nm, "_lane0"}, out_dec[DEC_W-1:0], d0);
    chk({nm, "_lane1"}, out_dec[2*DEC_W-1:DEC_W], d1);
  endtask

  initial begin
    p_add   = mk(1,1,1, 5'd3,  5'd2,  5'd1, 3'd0, 32'h0,        T_R, 0,0,0,0,0, 2'b00, 0);
    p_sub   = mk(1,1,1, 5'd5,  5'd7,  5'd6, 3'd0, 32'h0,        T_R, 1,0,0,0,0, 2'b00, 0);
    p_lw    = mk(1,0,1, 5'd4,  5'd28, 5'd2, 3'd2, 32'hFFFFFFFC, T_I, 0,0,0,0,1, 2'b10, 0);
    p_srai  = mk(1,0,1, 5'd1,  5'd3,  5'd1, 3'd5, 32'h00000403, T_I, 0,1,0,0,0, 2'b01, 1);
    p_sw    = mk(0,1,1, 5'd8,  5'd5,  5'd2, 3'd2, 32'h00000008, T_S, 0,0,0,0,1, 2'b10, 0);
    p_beq   = mk(0,1,1, 5'd25, 5'd2,  5'd1, 3'd0, 32'hFFFFFFF8, T_B, 0,0,0,0,0, 2'b00, 0);
    p_lui   = mk(1,0,0, 5'd7,  5'd3,  5'd8, 3'd5, 32'h12345000, T_U, 0,0,1,0,0, 2'b01, 1);
    p_jal   = mk(1,0,0, 5'd1,  5'd16, 5'd0, 3'd0, 32'h00000010, T_J, 0,0,0,0,0, 2'b00, 0);
    p_jalr  = mk(1,0,1, 5'd0,  5'd0,  5'd1, 3'd0, 32'h0,        T_I, 0,0,0,1,0, 2'b00, 0);
    p_auipc = mk(1,0,0, 5'd10, 5'd0,  5'd0, 3'd1, 32'h00001000, T_U, 0,0,0,0,0, 2'b01, 0);
`ifdef DECODE_ILLEGAL_DETECT_EN
    p_zero  = {1'b1, 67'h0};
`else
    p_zero  = '0;
`endif

    vecs[0] = '{2'b11, I_ADD,   I_SUB,  1, 2'b11, 3'd0, p_add,   p_sub};
    vecs[1] = '{2'b11, I_LW,    I_SRAI, 1, 2'b11, 3'd2, p_lw,    p_srai};
    vecs[2] = '{2'b10, I_ADD,   I_SUB,  0, 2'b00, 3'd0, '0,      '0};
    vecs[3] = '{2'b01, I_SW,    I_BEQ,  1, 2'b01, 3'd4, p_sw,    '0};
    vecs[4] = '{2'b11, I_BEQ,   I_LUI,  1, 2'b11, 3'd5, p_beq,   p_lui};
    vecs[5] = '{2'b11, I_JAL,   I_JALR, 1, 2'b11, 3'd7, p_jal,   p_jalr};
    vecs[6] = '{2'b11, I_AUIPC, I_ZERO, 1, 2'b11, 3'd1, p_auipc, p_zero};
    vecs[7] = '{2'b00, I_ADD,   I_SUB,  0, 2'b00, 3'd0, '0,      '0};

    // reset held with a group offered
    drive(1, 2'b11, I_ADD, I_SUB, 1, 0);
    tick();
    tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_seq", out_seq, 3'd0);
    chk("rst_mask", out_mask, 2'b00);
    chk("rst_dec", out_dec, '0);
    @(negedge clk);
    drive(0, 2'b00, 0, 0, 1, 0);
    rst_aL = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    for (int k = 0; k < 8; k++) begin
      drive(1, vecs[k].mask, vecs[k].i0, vecs[k].i1, 1, 0);
      #1;
      chk($sformatf("tbl%0d_in_ready", k), in_ready, 1'b1);
      tick();
      chk($sformatf("tbl%0d_valid", k), out_valid, vecs[k].ev);
      if (vecs[k].ev) begin
        chk($sformatf("tbl%0d_mask", k), out_mask, vecs[k].em);
        chk($sformatf("tbl%0d_seq", k), out_seq, vecs[k].es);
        chk($sformatf("tbl%0d_lane0", k), out_dec[DEC_W-1:0], vecs[k].d0);
        chk($sformatf("tbl%0d_lane1", k), out_dec[2*DEC_W-1:DEC_W], vecs[k].d1);
      end
    end

    // back-pressure: group A held for 3 cycles while group B waits
    drive(1, 2'b11, I_ADD, I_SUB, 1, 0);
    tick();
    chk_group("bp_a", 3'd3, p_add, p_sub);
    drive(1, 2'b11, I_LW, I_SRAI, 0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_stall%0d_in_ready", c), in_ready, 1'b0);
      tick();
      chk_group($sformatf("bp_stall%0d", c), 3'd3, p_add, p_sub);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    tick();
    chk_group("bp_b", 3'd5, p_lw, p_srai);

    // flush with a held group and a new group offered
    drive(1, 2'b11, I_JAL, I_JALR, 0, 1);
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    chk("flush_valid", out_valid, 1'b0);
    drive(1, 2'b11, I_BEQ, I_LUI, 1, 0);
    tick();
    chk_group("post_flush", 3'd7, p_beq, p_lui);
    drive(1, 2'b01, I_AUIPC, I_JAL, 1, 0);
    tick();
    chk_group("wrap", 3'd1, p_auipc, '0);
    chk("wrap_mask", out_mask, 2'b01);

    // pop with no new input
    drive(0, 2'b11, I_ADD, I_SUB, 1, 0);
    tick();
    chk("pop_valid", out_valid, 1'b0);

    // asynchronous reset while a group is held
    drive(1, 2'b11, I_SW, I_BEQ, 0, 0);
    tick();
    chk_group("pre_areset", 3'd2, p_sw, p_beq);
    #2;
    rst_aL = 1'b0;
    #1;
    chk("areset_valid", out_valid, 1'b0);
    chk("areset_seq", out_seq, 3'd0);
    chk("areset_dec", out_dec, '0);
    @(negedge clk);
    drive(1, 2'b11, I_LW, I_SRAI, 1, 0);
    rst_aL = 1'b1;
    tick();
    chk_group("after_areset", 3'd0, p_lw, p_srai);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
